// File: rtl/ptc_code_ctrl.sv
//==============================================================================
// ptc_code_ctrl : FMDLL PTC delay-code generator (SAR fast lock + filtered tracking)
// Revision      : 1.0
//==============================================================================
`default_nettype none

module ptc_code_ctrl #(
    parameter int CODE_W   = 10,
    parameter int FILT_TH  = 4,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              pd_valid,
    input  logic              pd_up,
    input  logic              pd_dn,
    output logic [CODE_W-1:0] Q,
    output logic              q_upd,
    output logic              locked,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAR   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam int IDX_W  = $clog2(CODE_W);
    localparam int FILT_W = 5;
    localparam int CNT_W  = 4;

    localparam logic [CODE_W-1:0]        C_SAR_INIT = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0]        C_CODE_MAX = '1;
    localparam logic [IDX_W-1:0]         C_IDX_MSB  = IDX_W'(CODE_W - 1);
    localparam logic signed [FILT_W-1:0] C_FILT_POS = FILT_W'(FILT_TH);
    localparam logic signed [FILT_W-1:0] C_FILT_NEG = -C_FILT_POS;
    localparam logic [CNT_W-1:0]         C_LOCK     = CNT_W'(LOCK_CNT);

    state_t                     state_q, state_d;
    logic [CODE_W-1:0]          code_q, code_d;
    logic                       upd_q, upd_d;
    logic                       locked_q, locked_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [FILT_W-1:0]   filt_q, filt_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       dir_vld_q, dir_vld_d;
    logic                       dir_up_q, dir_up_d;

    logic                       sample_w;
    logic signed [FILT_W-1:0]   filt_nxt_w;
    logic                       step_up_w;
    logic                       step_dn_w;
    logic                       step_ok_w;

    // A sample only counts when the detector gives an unambiguous direction.
    assign sample_w   = pd_valid & (pd_up ^ pd_dn);
    assign filt_nxt_w = pd_up ? (filt_q + 5'sd1) : (filt_q - 5'sd1);
    assign step_up_w  = (filt_nxt_w == C_FILT_POS);
    assign step_dn_w  = (filt_nxt_w == C_FILT_NEG);
    assign step_ok_w  = step_up_w ? (code_q != C_CODE_MAX) : (code_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            upd_q     <= 1'b0;
            locked_q  <= 1'b0;
            idx_q     <= C_IDX_MSB;
            filt_q    <= '0;
            cnt_q     <= '0;
            dir_vld_q <= 1'b0;
            dir_up_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            upd_q     <= upd_d;
            locked_q  <= locked_d;
            idx_q     <= idx_d;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
            dir_vld_q <= dir_vld_d;
            dir_up_q  <= dir_up_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        upd_d     = 1'b0;
        locked_d  = locked_q;
        idx_d     = idx_q;
        filt_d    = filt_q;
        cnt_d     = cnt_q;
        dir_vld_d = dir_vld_q;
        dir_up_d  = dir_up_q;

        if (!en) begin
            state_d   = ST_IDLE;
            locked_d  = 1'b0;
            filt_d    = '0;
            cnt_d     = '0;
            dir_vld_d = 1'b0;
        end else if (start) begin
            state_d   = ST_SAR;
            code_d    = C_SAR_INIT;
            idx_d     = C_IDX_MSB;
            upd_d     = 1'b1;
            locked_d  = 1'b0;
            filt_d    = '0;
            cnt_d     = '0;
            dir_vld_d = 1'b0;
        end else if (sample_w) begin
            case (state_q)
                ST_SAR: begin
                    // Resolve the trial bit, then arm the next lower bit as trial.
                    if (pd_dn) begin
                        code_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        code_d[idx_q - 1'b1] = 1'b1;
                        idx_d                = idx_q - 1'b1;
                    end else begin
                        state_d   = ST_TRACK;
                        filt_d    = '0;
                        cnt_d     = '0;
                        dir_vld_d = 1'b0;
                    end
                    upd_d = (code_d != code_q);
                end
                ST_TRACK: begin
                    filt_d = filt_nxt_w;
                    if (step_up_w || step_dn_w) begin
                        filt_d = '0;
                        // A step blocked at either end of the code range is discarded
                        // entirely so it cannot disturb the reversal history.
                        if (step_ok_w) begin
                            code_d    = step_up_w ? (code_q + 1'b1) : (code_q - 1'b1);
                            upd_d     = 1'b1;
                            dir_vld_d = 1'b1;
                            dir_up_d  = step_up_w;
                            if (dir_vld_q) begin
                                if (step_up_w != dir_up_q) begin
                                    if (cnt_q != C_LOCK) begin
                                        cnt_d = cnt_q + 1'b1;
                                    end
                                    if (cnt_q >= (C_LOCK - 1'b1)) begin
                                        locked_d = 1'b1;
                                    end
                                end else begin
                                    cnt_d    = '0;
                                    locked_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q      = code_q;
    assign q_upd  = upd_q;
    assign locked = locked_q;
    assign state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ptc_code_ctrl.sv
//==============================================================================
// tb_ptc_code_ctrl : scoreboard bench for ptc_code_ctrl against a behavioural model
// Revision         : 1.0
//==============================================================================
`default_nettype none

module tb_ptc_code_ctrl;

    localparam int FILT_TH  = 4;
    localparam int LOCK_CNT = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, start, pd_valid, pd_up, pd_dn;
    logic [9:0] Q;
    logic       q_upd, locked;
    logic [1:0] state;

    always #5 clk = ~clk;

    ptc_code_ctrl #(
        .CODE_W  (10),
        .FILT_TH (FILT_TH),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (start),
        .pd_valid(pd_valid),
        .pd_up   (pd_up),
        .pd_dn   (pd_dn),
        .Q       (Q),
        .q_upd   (q_upd),
        .locked  (locked),
        .state   (state)
    );

    typedef struct packed {
        logic [9:0] q;
        logic       upd;
        logic       lk;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   pushes   = 0;
    int   pops     = 0;

    // Reference model: code as an integer, SAR as a halving binary search,
    // direction history as -1/0/+1.
    int m_q = 0, m_upd = 0, m_lk = 0, m_st = 0, m_k = 9;
    int m_filt = 0, m_cnt = 0, m_last = 0;

    function automatic void model_step(bit r, bit e, bit s, bit v, bit u, bit d);
        int nq;
        int dir;
        m_upd = 0;
        if (!r) begin
            m_q = 0; m_lk = 0; m_st = 0; m_k = 9;
            m_filt = 0; m_cnt = 0; m_last = 0;
        end else if (!e) begin
            m_st = 0; m_lk = 0; m_filt = 0; m_cnt = 0; m_last = 0;
        end else if (s) begin
            m_st = 1; m_q = 512; m_k = 9; m_upd = 1; m_lk = 0;
        end else if (v && (u != d)) begin
            if (m_st == 1) begin
                nq = m_q;
                if (d) nq = nq - (1 << m_k);
                if (m_k > 0) begin
                    nq  = nq + (1 << (m_k - 1));
                    m_k = m_k - 1;
                end else begin
                    m_st = 2; m_filt = 0; m_cnt = 0; m_last = 0;
                end
                m_upd = (nq != m_q) ? 1 : 0;
                m_q   = nq;
            end else if (m_st == 2) begin
                m_filt = m_filt + (u ? 1 : -1);
                if (m_filt == FILT_TH || m_filt == -FILT_TH) begin
                    dir    = (m_filt > 0) ? 1 : -1;
                    m_filt = 0;
                    if (m_q + dir >= 0 && m_q + dir <= 1023) begin
                        m_q   = m_q + dir;
                        m_upd = 1;
                        if (m_last != 0) begin
                            if (dir != m_last) begin
                                if (m_cnt < LOCK_CNT) m_cnt = m_cnt + 1;
                                if (m_cnt >= LOCK_CNT) m_lk = 1;
                            end else begin
                                m_cnt = 0;
                                m_lk  = 0;
                            end
                        end
                        m_last = dir;
                    end
                end
            end
        end
    endfunction

    task automatic drive(input bit r, input bit e, input bit s, input bit v, input bit u, input bit d);
        exp_t x;
        rst_n = r; en = e; start = s; pd_valid = v; pd_up = u; pd_dn = d;
        model_step(r, e, s, v, u, d);
        x.q   = 10'(m_q);
        x.upd = (m_upd != 0);
        x.lk  = (m_lk != 0);
        x.st  = 2'(m_st);
        sb.push_back(x);
        pushes++;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic samp(input bit up);
        drive(1, 1, 0, 1, up, !up);
    endtask

    task automatic run_sar(input logic [9:0] target);
        drive(1, 1, 1, 0, 0, 0);
        for (int i = 9; i >= 0; i--) begin
            samp(target[i]);
        end
    endtask

    task automatic groups(input int n, input bit first_up);
        for (int g = 0; g < n; g++) begin
            for (int j = 0; j < FILT_TH; j++) samp(first_up ^ g[0]);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output word; compare it to the
    // oldest outstanding prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                pops++;
                checks++;
                if ({Q, q_upd, locked, state} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_cycle t=%0t actual Q=%h upd=%b lk=%b st=%0d expected Q=%h upd=%b lk=%b st=%0d",
                             $time, Q, q_upd, locked, state, mon_e.q, mon_e.upd, mon_e.lk, mon_e.st);
                end
            end
        end
    end

    initial begin
        int r, bias, wait_cyc;
        bit rv, ev, sv, vv, uv, dv;

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 1, 0);
        chk("reset_Q", Q, 0);
        chk("reset_state", state, 0);
        chk("reset_locked", locked, 0);
        chk("reset_upd", q_upd, 0);
        drive(1, 1, 0, 1, 1, 0);
        chk("idle_ignores_pd", Q, 0);

        run_sar(10'b1011000101);
        chk("sar_Q", Q, 10'h2C5);
        chk("sar_state", state, 2);

        run_sar(10'h200);
        for (int i = 0; i < 3; i++) samp(1);
        chk("filt_hold_Q", Q, 10'h200);
        samp(1);
        chk("filt_step_Q", Q, 10'h201);
        chk("filt_step_upd", q_upd, 1);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 1, 1);
        chk("null_Q", Q, 10'h201);
        chk("null_upd", q_upd, 0);

        run_sar(10'h3FF);
        for (int i = 0; i < 8; i++) samp(1);
        chk("sat_hi_Q", Q, 1023);
        chk("sat_hi_upd", q_upd, 0);
        groups(1, 0);
        chk("sat_hi_dn_Q", Q, 1022);
        run_sar(10'h000);
        groups(2, 0);
        groups(1, 0);
        chk("sat_lo_Q", Q, 0);

        run_sar(10'h200);
        groups(5, 1);
        chk("lock_Q", Q, 10'h201);
        chk("lock_set", locked, 1);
        groups(1, 1);
        chk("lock_drop", locked, 0);
        chk("lock_drop_Q", Q, 10'h202);

        run_sar(10'h155);
        groups(5, 1);
        chk("pre_rst_locked", locked, 1);
        drive(0, 1, 0, 1, 1, 0);
        chk("mid_rst_Q", Q, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_state", state, 0);

        run_sar(10'h200);
        groups(5, 1);
        drive(1, 1, 1, 1, 1, 0);
        chk("restart_Q", Q, 10'h200);
        chk("restart_state", state, 1);
        chk("restart_locked", locked, 0);
        drive(1, 0, 1, 1, 1, 0);
        chk("en_low_state", state, 0);
        chk("en_low_Q", Q, 10'h200);

        bias = 50;
        for (int c = 0; c < 5000; c++) begin
            r  = $urandom_range(0, 999);
            rv = (r >= 3);
            ev = ($urandom_range(0, 99) != 0);
            sv = ($urandom_range(0, 199) == 0);
            vv = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) begin
                uv = 1'($urandom_range(0, 1));
                dv = uv;
            end else begin
                uv = ($urandom_range(0, 99) < bias);
                dv = !uv;
            end
            if (sv || $urandom_range(0, 299) == 0) bias = $urandom_range(10, 90);
            drive(rv, ev, sv, vv, uv, dv);
        end

        drive(1, 1, 0, 0, 0, 0);
        wait_cyc = 0;
        while (pops != pushes && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        chk("sb_drain", pops, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ptc_code_ctrl.md
Name: ptc_code_ctrl

Overview:
- Phase-tuning control word generator for the FMDLL PTC path.
- Consumes phase-detector UP/DN samples and produces the 10-bit delay code Q[9:0] that feeds the 4-to-16 coarse-tap decoder (Q[9:6] coarse, Q[5:0] fine).
- Locks in two phases:
  - fast lock: 10-step successive-approximation (SAR) search;
  - tracking: filtered ±1 steps.
- Reports lock status.

Parameters:
- CODE_W, 10, code width. Fixed at 10 to match the decoder; other values unsupported.
- FILT_TH, 4, tracking-filter threshold. Range 2..15.
- LOCK_CNT, 4, consecutive direction reversals in TRACK required to assert locked. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  block enable; low forces IDLE and holds Q.
- start  in  1  single-cycle pulse; starts or restarts SAR search.
- pd_valid  in  1  phase-detector sample strobe.
- pd_up  in  1  delay too short; increase code. Sampled only when pd_valid=1.
- pd_dn  in  1  delay too long; decrease code. Sampled only when pd_valid=1.
- Q  out  10  delay control code, registered.
- q_upd  out  1  one-cycle pulse in the cycle Q holds a new value.
- locked  out  1  lock indicator, registered.
- state  out  2  state: 0=IDLE, 1=SAR, 2=TRACK.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Q=0, q_upd=0, locked=0, state=IDLE.
  - SAR bit index=9, filter=0, reversal count=0, last-step direction cleared.
  - Reset overrides all other inputs, including mid-SAR and mid-TRACK.
- Valid sample: a cycle with pd_valid=1 and exactly one of pd_up/pd_dn high.
  - pd_valid=1 with both or neither high is a null sample: no state change, no q_upd.
- Latency: a valid sample at edge N is reflected on Q/q_upd/locked after edge N (visible in cycle N+1).
- IDLE:
  - Q held.
  - start=1 and en=1 → SAR: Q=10'b10_0000_0000, bit index=9, q_upd=1, locked=0.
- SAR, one valid sample per bit:
  - pd_dn: clear Q[idx].
  - pd_up: keep Q[idx].
  - If idx>0: set Q[idx-1] and decrement idx; q_upd=1 whenever Q changes.
  - After the idx=0 decision → TRACK; filter=0, reversal count=0, no last direction.
  - 10 valid samples complete the search, and the result equals the binary search outcome.
- TRACK:
  - Signed filter: +1 on pd_up, -1 on pd_dn.
  - Filter reaches +FILT_TH: Q←Q+1, filter←0, step dir=UP.
  - Filter reaches -FILT_TH: Q←Q-1, filter←0, step dir=DN.
- Saturation:
  - UP step at Q=1023 or DN step at Q=0: Q held, filter←0, no q_upd.
  - A saturated step is not counted and does not update last direction.
- Lock detection, TRACK only, evaluated on each non-saturated step:
  - Step opposite to last direction: reversal count+1; locked=1 when count reaches LOCK_CNT; count saturates.
  - Step same as last direction: count←0, locked←0.
  - The first step after entering TRACK only records direction.
- start while in SAR or TRACK:
  - Restarts SAR: same as the IDLE→SAR transition, locked←0.
  - start has priority over a same-cycle pd sample.
- en=0 in any state:
  - Next state IDLE, locked←0, Q held, filter/count cleared.
  - A same-cycle start or sample is ignored.
- State is ignored outside SAR/TRACK. pd inputs are ignored in IDLE.
- Simultaneous events, priority: rst_n > en=0 > start > pd sample.

Test Plan:
- Reset mid-TRACK with Q=0x155, locked=1; assert rst_n=0 for one edge → Q=0, locked=0, state=0, q_upd=0.
- start, then 10 valid samples with pattern up,dn,up,up,dn,dn,dn,up,dn,up (first is bit 9) → final Q=10'b1011000101=0x2C5; state=2 after the 10th sample; exactly 10 q_upd pulses at most.
- In TRACK at Q=0x200 with FILT_TH=4: 3 pd_up samples → no change; 4th → Q=0x201 next cycle with a single q_upd; then null samples (both high) → Q unchanged.
- Saturation: TRACK at Q=1023, 8 pd_up samples → Q stays 1023, no q_upd, reversal count unchanged; then 4 pd_dn → Q=1022.
- Lock with LOCK_CNT=4 and FILT_TH=4: alternating groups of 4 up / 4 dn → Q toggles 0x200↔0x201; locked=1 after the 5th step (4th reversal); then two consecutive UP steps → locked=0.
- start asserted in the same cycle as a valid pd_up in TRACK → Q=0x200, state=1, locked=0. Then en=0 → state=0, Q held at 0x200.
